// File: rtl/cacheline_adapter_pkg.sv
// Shared types and sizing for the cache-line to bmem burst adapter.
// The beat count is derived from the line and beat widths and cannot be overridden.
package cacheline_adapter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;
  localparam int unsigned BEAT_W = 64;
  localparam int unsigned BEATS  = LINE_W / BEAT_W;
  localparam int unsigned CNT_W  = $clog2(BEATS);
  localparam int unsigned OFFS_W = $clog2(LINE_W / 8);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_BURST,
    RESP
  } adapter_state_t;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [LINE_W-1:0] line_t;
  typedef logic [BEAT_W-1:0] beat_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  // Clears the byte offset so every burst starts on a line boundary.
  function automatic addr_t line_base(input addr_t a);
    return {a[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cacheline_adapter_if.sv
// Cache dfp port plus bmem burst port bundled together.
// slave is the adapter's view; master is the surrounding cache and memory.
interface cacheline_adapter_if;
  import cacheline_adapter_pkg::*;

  addr_t dfp_addr;
  logic  dfp_read;
  logic  dfp_write;
  line_t dfp_wdata;
  line_t dfp_rdata;
  logic  dfp_resp;

  addr_t bmem_addr;
  logic  bmem_read;
  logic  bmem_write;
  beat_t bmem_wdata;
  logic  bmem_ready;
  addr_t bmem_raddr;
  beat_t bmem_rdata;
  logic  bmem_rvalid;

  modport slave (
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output dfp_rdata, dfp_resp,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );

  modport master (
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  dfp_rdata, dfp_resp,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );

endinterface

// File: rtl/cacheline_adapter.sv
// Runs one cache line read or write as a 4-beat burst on bmem and returns a
// single-cycle completion pulse (with the assembled line on reads) to the cache.
module cacheline_adapter
  import cacheline_adapter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  cacheline_adapter_if.slave bus
);

  adapter_state_t state_q, state_d;
  cnt_t           cnt_q,   cnt_d;
  addr_t          addr_q,  addr_d;
  line_t          wline_q, wline_d;
  line_t          rline_q, rline_d;

  logic last_beat_c;
  logic beat_hit_c;

  assign last_beat_c = (cnt_q == CNT_W'(BEATS - 1));
  // Beats tagged for another line are stray and must not be stored.
  assign beat_hit_c  = bus.bmem_rvalid && (bus.bmem_raddr == addr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

  // bmem_* come only from state and latched registers, never from dfp inputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;

    bus.bmem_addr  = '0;
    bus.bmem_read  = 1'b0;
    bus.bmem_write = 1'b0;
    bus.bmem_wdata = '0;
    bus.dfp_resp   = 1'b0;
    bus.dfp_rdata  = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.dfp_write) begin
          addr_d  = line_base(bus.dfp_addr);
          wline_d = bus.dfp_wdata;
          cnt_d   = '0;
          state_d = WR_BURST;
        end else if (bus.dfp_read) begin
          addr_d  = line_base(bus.dfp_addr);
          state_d = RD_REQ;
        end
      end

      RD_REQ: begin
        bus.bmem_read = 1'b1;
        bus.bmem_addr = addr_q;
        if (bus.bmem_ready) begin
          cnt_d   = '0;
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (beat_hit_c) begin
          rline_d[int'(cnt_q)*BEAT_W +: BEAT_W] = bus.bmem_rdata;
          cnt_d = CNT_W'(cnt_q + 1'b1);
          if (last_beat_c) begin
            state_d = RESP;
          end
        end
      end

      WR_BURST: begin
        bus.bmem_write = 1'b1;
        bus.bmem_addr  = addr_q;
        bus.bmem_wdata = wline_q[int'(cnt_q)*BEAT_W +: BEAT_W];
        if (bus.bmem_ready) begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
          if (last_beat_c) begin
            state_d = RESP;
          end
        end
      end

      RESP: begin
        bus.dfp_resp  = 1'b1;
        bus.dfp_rdata = rline_q;
        state_d       = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
